// File: rtl/wolf_geom_pkg.sv
// Shared geometry definitions for the segment-intersection unit:
// FSM encoding, derived datapath widths and rounding constants.
package wolf_geom_pkg;

  typedef enum logic [2:0] {S_IDLE, S_COEF, S_PROD, S_DIV, S_DONE} state_t;

  // Signed numerator width: |b1*c2 - b2*c1| < 2^(3*COORD_W+2), plus sign, headroom and FRAC_W.
  function automatic int num_w(input int coord_w, input int frac_w);
    return 3*coord_w + 4 + frac_w;
  endfunction

  function automatic int den_w(input int coord_w);
    return 2*coord_w + 3;
  endfunction

  // Half the divisor is added to the magnitude before dividing (round half away from zero).
  localparam int ROUND_DIV_SHIFT = 1;

endpackage

// File: rtl/segment_intersect_seq_if.sv
// Request/response bundle between the ray generator, the intersect unit and the wall-hit selector.
interface segment_intersect_seq_if #(
  parameter int COORD_W = 10,
  parameter int FRAC_W  = 0
);
  logic                      in_valid;
  logic                      in_ready;
  logic [COORD_W-1:0]        x1, y1, x2, y2, x3, y3, x4, y4;
  logic                      out_valid;
  logic                      out_ready;
  logic                      are_intersecting;
  logic                      out_of_range;
  logic [COORD_W+FRAC_W-1:0] intersect_x;
  logic [COORD_W+FRAC_W-1:0] intersect_y;

  modport slave (
    input  in_valid, x1, y1, x2, y2, x3, y3, x4, y4, out_ready,
    output in_ready, out_valid, are_intersecting, out_of_range, intersect_x, intersect_y
  );

  modport master (
    output in_valid, x1, y1, x2, y2, x3, y3, x4, y4, out_ready,
    input  in_ready, out_valid, are_intersecting, out_of_range, intersect_x, intersect_y
  );
endinterface

// File: rtl/seq_divider_u.sv
// Unsigned restoring divider, one quotient bit per cycle (N_W cycles after start).
// done stays high until the next start.
module seq_divider_u #(
  parameter int N_W = 34,
  parameter int D_W = 23
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] num,
  input  logic [D_W-1:0] den,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] quo
);
  localparam int CNT_W = $clog2(N_W + 1);

  logic [D_W-1:0]   rem, dreg;
  logic [CNT_W-1:0] cnt;
  logic [D_W:0]     rem_sh, diff;

  // rem < den always, so a non-negative difference never sets the top bit.
  always_comb begin
    rem_sh = {rem, quo[N_W-1]};
    diff   = rem_sh - {1'b0, dreg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      dreg <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      rem  <= '0;
      dreg <= den;
      quo  <= num;
      cnt  <= CNT_W'(N_W);
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      if (diff[D_W]) begin
        rem <= rem_sh[D_W-1:0];
        quo <= {quo[N_W-2:0], 1'b0};
      end else begin
        rem <= diff[D_W-1:0];
        quo <= {quo[N_W-2:0], 1'b1};
      end
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/segment_intersect_seq.sv
// Sequential 2-D segment intersection: coefficients, cross products, hit test,
// then two parallel dividers produce the rounded, clamped intersection point.
module segment_intersect_seq
  import wolf_geom_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int FRAC_W  = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  segment_intersect_seq_if.slave bus
);
  localparam int NUM_W = num_w(COORD_W, FRAC_W);
  localparam int DEN_W = den_w(COORD_W);
  localparam int OUT_W = COORD_W + FRAC_W;

  typedef logic signed [NUM_W-1:0] sword_t;

  state_t                    state;
  logic [3:0][COORD_W-1:0]   px, py;
  sword_t                    a1, b1, c1, a2, b2, c2;
  logic                      neg_x, neg_y;
  logic                      in_ready_q, out_valid_q, hit_q, oor_q;
  logic [OUT_W-1:0]          ix_q, iy_q;

  sword_t                    nx, ny, r1, r2, r3, r4;
  logic signed [DEN_W-1:0]   denom;
  logic [DEN_W-1:0]          dmag;
  logic [NUM_W-1:0]          num_x, num_y, q_x, q_y;
  logic                      hit, div_start, busy_x, busy_y, done_x, done_y;
  logic [OUT_W:0]            fx, fy;

  function automatic sword_t sx(input logic [COORD_W-1:0] v);
    return $signed({{(NUM_W-COORD_W){1'b0}}, v});
  endfunction

  function automatic logic [NUM_W-1:0] absn(input sword_t v);
    return v[NUM_W-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  // Both endpoints strictly on the same side of the other line; a zero means touching.
  function automatic logic same_side(input sword_t ra, input sword_t rb);
    return (ra != '0) && (rb != '0) && (ra[NUM_W-1] == rb[NUM_W-1]);
  endfunction

  // {out_of_range, value}: negative results clamp to 0, oversized ones to all-ones.
  function automatic logic [OUT_W:0] fix(input logic [NUM_W-1:0] q, input logic neg);
    if (neg && (q != '0))    return {1'b1, {OUT_W{1'b0}}};
    if (|q[NUM_W-1:OUT_W])   return {1'b1, {OUT_W{1'b1}}};
    return {1'b0, q[OUT_W-1:0]};
  endfunction

  always_comb begin
    denom = DEN_W'(a1*b2 - a2*b1);
    r3    = a1*sx(px[2]) + b1*sx(py[2]) + c1;
    r4    = a1*sx(px[3]) + b1*sx(py[3]) + c1;
    r1    = a2*sx(px[0]) + b2*sx(py[0]) + c2;
    r2    = a2*sx(px[1]) + b2*sx(py[1]) + c2;
    nx    = (b1*c2 - b2*c1) <<< FRAC_W;
    ny    = (a2*c1 - a1*c2) <<< FRAC_W;
    hit   = (denom != '0) && !same_side(r3, r4) && !same_side(r1, r2);
    dmag  = denom[DEN_W-1] ? $unsigned(-denom) : $unsigned(denom);
    num_x = absn(nx) + {{(NUM_W-DEN_W){1'b0}}, dmag >> ROUND_DIV_SHIFT};
    num_y = absn(ny) + {{(NUM_W-DEN_W){1'b0}}, dmag >> ROUND_DIV_SHIFT};
    div_start = (state == S_PROD) && hit;
    fx    = fix(q_x, neg_x);
    fy    = fix(q_y, neg_y);
  end

  seq_divider_u #(.N_W(NUM_W), .D_W(DEN_W)) u_div_x (
    .clk(clk), .rst_n(rst_n), .start(div_start), .num(num_x), .den(dmag),
    .busy(busy_x), .done(done_x), .quo(q_x)
  );

  seq_divider_u #(.N_W(NUM_W), .D_W(DEN_W)) u_div_y (
    .clk(clk), .rst_n(rst_n), .start(div_start), .num(num_y), .den(dmag),
    .busy(busy_y), .done(done_y), .quo(q_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      px          <= '0;
      py          <= '0;
      {a1, b1, c1, a2, b2, c2} <= '0;
      neg_x       <= 1'b0;
      neg_y       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      oor_q       <= 1'b0;
      ix_q        <= '0;
      iy_q        <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          px         <= {bus.x4, bus.x3, bus.x2, bus.x1};
          py         <= {bus.y4, bus.y3, bus.y2, bus.y1};
          in_ready_q <= 1'b0;
          state      <= S_COEF;
        end
        S_COEF: begin
          a1    <= sx(py[1]) - sx(py[0]);
          b1    <= sx(px[0]) - sx(px[1]);
          c1    <= sx(px[1])*sx(py[0]) - sx(px[0])*sx(py[1]);
          a2    <= sx(py[3]) - sx(py[2]);
          b2    <= sx(px[2]) - sx(px[3]);
          c2    <= sx(px[3])*sx(py[2]) - sx(px[2])*sx(py[3]);
          state <= S_PROD;
        end
        S_PROD: begin
          neg_x <= nx[NUM_W-1] ^ denom[DEN_W-1];
          neg_y <= ny[NUM_W-1] ^ denom[DEN_W-1];
          state <= hit ? S_DIV : S_DONE;
        end
        S_DIV: if (done_x && done_y && !busy_x && !busy_y) begin
          hit_q       <= 1'b1;
          oor_q       <= fx[OUT_W] | fy[OUT_W];
          ix_q        <= fx[OUT_W-1:0];
          iy_q        <= fy[OUT_W-1:0];
          out_valid_q <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: begin
          // A miss arrives here with out_valid low and publishes a zero result first.
          if (!out_valid_q) begin
            hit_q       <= 1'b0;
            oor_q       <= 1'b0;
            ix_q        <= '0;
            iy_q        <= '0;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready         = in_ready_q;
  assign bus.out_valid        = out_valid_q;
  assign bus.are_intersecting = hit_q;
  assign bus.out_of_range     = oor_q;
  assign bus.intersect_x      = ix_q;
  assign bus.intersect_y      = iy_q;
endmodule

// File: tb/tb_segment_intersect_seq.sv
// Directed bench: parametric-line reference model plus literal expectations.
module tb_segment_intersect_seq;
  localparam int CW    = 10;
  localparam int FW    = 0;
  localparam int NUM_W = 3*CW + 4 + FW;

  typedef struct {
    int p[8];
    int hit;
    int x;
    int y;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  segment_intersect_seq_if #(.COORD_W(CW), .FRAC_W(FW)) bus0 ();
  segment_intersect_seq_if #(.COORD_W(CW), .FRAC_W(1))  bus1 ();

  segment_intersect_seq #(.COORD_W(CW), .FRAC_W(FW)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  segment_intersect_seq #(.COORD_W(CW), .FRAC_W(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int     checks = 0;
  int     errors = 0;
  bit     pending = 1'b0;
  bit     exp_hit, exp_oor;
  longint exp_x, exp_y;
  vec_t   vecs[7];

  function automatic longint orient(longint ax, longint ay, longint bx, longint by, longint cx, longint cy);
    return (bx-ax)*(cy-ay) - (by-ay)*(cx-ax);
  endfunction

  function automatic longint rnd(longint n, longint d);
    if (n >= 0) return (2*n + d) / (2*d);
    return -((-2*n + d) / (2*d));
  endfunction

  // Intersection P1 + t*(P2-P1) with t = tn/d, rounded, clamped to the output range.
  function automatic void model(input int p[8], input int fw, output bit hit, output bit oor,
                                output longint x, output longint y);
    longint x1 = p[0], y1 = p[1], x2 = p[2], y2 = p[3];
    longint x3 = p[4], y3 = p[5], x4 = p[6], y4 = p[7];
    longint d, tn, xn, yn, mx;
    mx  = (longint'(1) << (CW + fw)) - 1;
    d   = (x2-x1)*(y4-y3) - (y2-y1)*(x4-x3);
    hit = (d != 0) && !(orient(x1,y1,x2,y2,x3,y3) * orient(x1,y1,x2,y2,x4,y4) > 0)
                   && !(orient(x3,y3,x4,y4,x1,y1) * orient(x3,y3,x4,y4,x2,y2) > 0);
    oor = 1'b0;
    x   = 0;
    y   = 0;
    if (!hit) return;
    tn = (x3-x1)*(y4-y3) - (y3-y1)*(x4-x3);
    xn = (x1*d + tn*(x2-x1)) * (longint'(1) << fw);
    yn = (y1*d + tn*(y2-y1)) * (longint'(1) << fw);
    if (d < 0) begin xn = -xn; yn = -yn; d = -d; end
    x = rnd(xn, d);
    y = rnd(yn, d);
    if (x < 0) begin x = 0; oor = 1'b1; end
    if (x > mx) begin x = mx; oor = 1'b1; end
    if (y < 0) begin y = 0; oor = 1'b1; end
    if (y > mx) begin y = mx; oor = 1'b1; end
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus0.out_valid) begin
      checks++;
      if (!pending || bus0.are_intersecting !== exp_hit || bus0.out_of_range !== exp_oor ||
          longint'(bus0.intersect_x) != exp_x || longint'(bus0.intersect_y) != exp_y) begin
        errors++;
        $display("FAIL result: got hit=%0d oor=%0d x=%0d y=%0d want hit=%0d oor=%0d x=%0d y=%0d pending=%0d",
                 bus0.are_intersecting, bus0.out_of_range, bus0.intersect_x, bus0.intersect_y,
                 exp_hit, exp_oor, exp_x, exp_y, pending);
      end
    end
  end

  task automatic set_pts(input int p[8]);
    bus0.x1 = CW'(p[0]); bus0.y1 = CW'(p[1]); bus0.x2 = CW'(p[2]); bus0.y2 = CW'(p[3]);
    bus0.x3 = CW'(p[4]); bus0.y3 = CW'(p[5]); bus0.x4 = CW'(p[6]); bus0.y4 = CW'(p[7]);
  endtask

  task automatic drive_accept(input int p[8]);
    int n = 0;
    @(negedge clk);
    set_pts(p);
    bus0.in_valid = 1'b1;
    while (!bus0.in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("accept_timeout", n, 0);
    model(p, FW, exp_hit, exp_oor, exp_x, exp_y);
    @(posedge clk);
    #1 bus0.in_valid = 1'b0;
    pending = 1'b1;
  endtask

  task automatic wait_result();
    int lat = 0;
    while (!bus0.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, exp_hit ? NUM_W + 3 : 3);
  endtask

  task automatic consume(input int hold);
    int junk[8] = '{7, 7, 9, 1, 3, 3, 8, 2};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("busy_in_ready", bus0.in_ready, 0);
      set_pts(junk);
      bus0.in_valid = 1'b1;
    end
    @(negedge clk);
    bus0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b0;
    pending        = 1'b0;
    chk("out_valid_drop", bus0.out_valid, 0);
    chk("in_ready_back", bus0.in_ready, 1);
  endtask

  initial begin
    bit     mh, mo;
    longint mx, my;
    int     n;

    vecs[0] = '{'{0, 0, 10, 10, 0, 10, 10, 0},     1, 5, 5};
    vecs[1] = '{'{0, 0, 3, 1, 0, 1, 3, 0},         1, 2, 1};
    vecs[2] = '{'{0, 0, 10, 0, 0, 5, 10, 5},       0, 0, 0};
    vecs[3] = '{'{0, 0, 2, 2, 10, 0, 0, 10},       0, 0, 0};
    vecs[4] = '{'{0, 0, 10, 0, 5, 0, 5, 9},        1, 5, 0};
    vecs[5] = '{'{0, 0, 1023, 1023, 0, 1023, 1023, 0}, 1, 512, 512};
    vecs[6] = '{'{100, 200, 900, 700, 50, 800, 1000, 100}, -1, 0, 0};

    bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    set_pts(vecs[0].p);
    bus1.x1 = 0; bus1.y1 = 0; bus1.x2 = 3; bus1.y2 = 1;
    bus1.x3 = 0; bus1.y3 = 1; bus1.x4 = 3; bus1.y4 = 0;

    #2 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", bus0.in_ready, 1);
    chk("rst_out_valid", bus0.out_valid, 0);
    chk("rst_flags", {bus0.are_intersecting, bus0.out_of_range}, 0);
    chk("rst_xy", {bus0.intersect_x, bus0.intersect_y}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].hit >= 0) begin
        model(vecs[i].p, FW, mh, mo, mx, my);
        chk($sformatf("model_v%0d", i), {mh, mo, 16'(mx), 16'(my)},
            {vecs[i].hit[0], 1'b0, 16'(vecs[i].x), 16'(vecs[i].y)});
      end
    end
    model(vecs[1].p, 1, mh, mo, mx, my);
    chk("model_frac1", {mh, mo, 16'(mx), 16'(my)}, {1'b1, 1'b0, 16'd3, 16'd1});

    for (int i = 0; i < 7; i++) begin
      drive_accept(vecs[i].p);
      wait_result();
      if (vecs[i].hit >= 0) begin
        chk($sformatf("lit_hit_v%0d", i), bus0.are_intersecting, vecs[i].hit);
        chk($sformatf("lit_xy_v%0d", i), {bus0.intersect_x, bus0.intersect_y},
            {CW'(vecs[i].x), CW'(vecs[i].y)});
      end
      consume(i == 0 ? 5 : 0);
    end

    drive_accept(vecs[5].p);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus0.out_valid, 0);
    chk("midrst_in_ready", bus0.in_ready, 1);
    pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_accept(vecs[5].p);
    wait_result();
    chk("after_rst_xy", {bus0.intersect_x, bus0.intersect_y}, {10'd512, 10'd512});
    consume(0);

    @(negedge clk);
    bus1.in_valid = 1'b1;
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
    n = 0;
    while (!bus1.out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk("frac1_latency", n, 3*CW + 4 + 1 + 3);
    chk("frac1_xy", {bus1.are_intersecting, bus1.out_of_range, bus1.intersect_x, bus1.intersect_y},
        {1'b1, 1'b0, 11'd3, 11'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
